// File: rtl/fetch_pkg.sv
// fetch_pkg: types and constants shared by the fetch stage and the extension unit.
package fetch_pkg;
    typedef enum logic [1:0] {S_BOOT, S_REQ, S_HOLD} state_t;
    localparam logic [31:0] DEFAULT_PC_STEP = 32'd4;
    localparam logic [5:0] OP_LW  = 6'b100000;
    localparam logic [5:0] OP_SW  = 6'b100001;
    localparam logic [5:0] OP_BEQ = 6'b110000;
    localparam logic [5:0] OP_J   = 6'b110001;
    function automatic logic [31:0] align_word(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/pc_register.sv
// pc_register: PC flop with redirect/sequential select and sticky misalignment flag.
module pc_register
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        seq_en,
    input  logic        redir_en,
    input  logic [31:0] seq_pc,
    input  logic [31:0] redirect_target,
    output logic [31:0] pc,
    output logic        fetch_err
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            fetch_err <= 1'b0;
        end else begin
            pc <= redir_en ? align_word(redirect_target) : seq_en ? seq_pc : pc;
            if (redir_en && redirect_target[1:0] != 2'b00) fetch_err <= 1'b1;
        end
    end
endmodule

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: PC, imem req/ack fetch, instruction register and decode handshake.
module instr_fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [5:0]  opcode,
    output logic [15:0] num16bits,
    output logic [25:0] num26bits,
    output logic [31:0] npc,
    output logic [31:0] pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        fetch_err
);
    state_t      state, state_nxt;
    logic [31:0] ir;
    logic        redir, take, seq_en;
    assign redir  = redirect_valid && state != S_BOOT;
    assign take   = state == S_REQ && imem_ack && !redir;
    assign seq_en = state == S_HOLD && ir_ready;
    // Redirect wins over both ack and ready; it always restarts at S_REQ.
    always_comb begin
        state_nxt = state;
        state_nxt = state == S_BOOT ? S_REQ :
                    redir           ? S_REQ :
                    take            ? S_HOLD :
                    seq_en          ? S_REQ : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_BOOT;
            ir    <= '0;
            npc   <= '0;
        end else begin
            state <= state_nxt;
            if (take) begin
                ir  <= imem_rdata;
                npc <= pc + PC_STEP;
            end
        end
    end
    pc_register #(.RESET_PC(RESET_PC)) u_pc (
        .clk             (clk),
        .rst_n           (rst_n),
        .seq_en          (seq_en),
        .redir_en        (redir),
        .seq_pc          (npc),
        .redirect_target (redirect_target),
        .pc              (pc),
        .fetch_err       (fetch_err)
    );
    assign imem_req  = state == S_REQ;
    assign ir_valid  = state == S_HOLD;
    assign imem_addr = pc;
    assign opcode    = ir[31:26];
    assign num16bits = ir[15:0];
    assign num26bits = ir[25:0];
endmodule
